// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: 2-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Define CLA_ADDER_PIPE_FLAGS_EN to add registered zero (zf) and negative (nf) result flags.
module cla_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             p,
    output logic             g
`ifdef CLA_ADDER_PIPE_FLAGS_EN
    ,
    output logic             zf,
    output logic             nf
`endif
);
    localparam int NG  = WIDTH / GROUP;
    localparam int NB  = (NG + 3) / 4;
    localparam int NGP = 4 * NB;

    if (GROUP != 4 || WIDTH % GROUP != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_cfg
        $error("cla_adder_pipe: GROUP must be 4 and WIDTH a multiple of it in 8..64");
    end

    function automatic logic gen4(input logic [3:0] pp, input logic [3:0] gg);
        return gg[3] | (pp[3] & gg[2]) | (&pp[3:2] & gg[1]) | (&pp[3:1] & gg[0]);
    endfunction

    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s2_load;
    logic [WIDTH-1:0] s1_p_q, s1_g_q, s1_p_d, s1_g_d, bx;
    logic [NG-1:0]    s1_gp_q, s1_gg_q, s1_gp_d, s1_gg_d;
    logic             s1_c0_q, s1_amsb_q, s1_bmsb_q;
    logic [NGP-1:0]   gpx, ggx, cgx;
    logic [NB-1:0]    bp, bg;
    logic [NB:0]      bc;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, wp_q, wp_d, wg_q, wg_d;

    assign s2_load    = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_load;
    assign s1_valid_d = in_ready ? in_valid : s1_valid_q;
    assign s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;

    always_comb begin
        bx      = sub ? ~b : b;
        s1_p_d  = a ^ bx;
        s1_g_d  = a & bx;
        s1_gp_d = '0;
        s1_gg_d = '0;
        for (int i = 0; i < NG; i++) begin
            s1_gp_d[i] = &s1_p_d[4*i +: 4];
            s1_gg_d[i] = gen4(s1_p_d[4*i +: 4], s1_g_d[4*i +: 4]);
        end
    end

    // Groups past NG in the last block are padded as pure propagates so block terms pass through.
    always_comb begin
        gpx          = '1;
        ggx          = '0;
        gpx[NG-1:0]  = s1_gp_q;
        ggx[NG-1:0]  = s1_gg_q;
        bp           = '0;
        bg           = '0;
        bc           = '0;
        cgx          = '0;
        c            = '0;
        wg_d         = 1'b0;
        for (int j = 0; j < NB; j++) begin
            bp[j] = &gpx[4*j +: 4];
            bg[j] = gen4(gpx[4*j +: 4], ggx[4*j +: 4]);
        end
        bc[0] = s1_c0_q;
        for (int j = 0; j < NB; j++) begin
            bc[j+1] = bg[j] | (bp[j] & bc[j]);
            wg_d    = bg[j] | (bp[j] & wg_d);
        end
        for (int j = 0; j < NB; j++) begin
            cgx[4*j] = bc[j];
            for (int k = 0; k < 3; k++)
                cgx[4*j+k+1] = ggx[4*j+k] | (gpx[4*j+k] & cgx[4*j+k]);
        end
        for (int i = 0; i < NG; i++) begin
            c[4*i] = cgx[i];
            for (int k = 0; k < 3; k++)
                c[4*i+k+1] = s1_g_q[4*i+k] | (s1_p_q[4*i+k] & c[4*i+k]);
        end
        c[WIDTH] = bc[NB];
        sum_d    = s1_p_q ^ c[WIDTH-1:0];
        cout_d   = c[WIDTH];
        ovf_d    = (s1_amsb_q ~^ s1_bmsb_q) & (s1_amsb_q ^ sum_d[WIDTH-1]);
        wp_d     = &s1_gp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_p_q     <= '0;
            s1_g_q     <= '0;
            s1_gp_q    <= '0;
            s1_gg_q    <= '0;
            s1_c0_q    <= 1'b0;
            s1_amsb_q  <= 1'b0;
            s1_bmsb_q  <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wp_q       <= 1'b0;
            wg_q       <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_valid && in_ready) begin
                s1_p_q    <= s1_p_d;
                s1_g_q    <= s1_g_d;
                s1_gp_q   <= s1_gp_d;
                s1_gg_q   <= s1_gg_d;
                s1_c0_q   <= sub | cin;
                s1_amsb_q <= a[WIDTH-1];
                s1_bmsb_q <= bx[WIDTH-1];
            end
            if (s2_load && s1_valid_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                wp_q   <= wp_d;
                wg_q   <= wg_d;
            end
        end
    end

`ifdef CLA_ADDER_PIPE_FLAGS_EN
    logic zf_q, nf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q <= 1'b0;
            nf_q <= 1'b0;
        end else if (s2_load && s1_valid_q) begin
            zf_q <= ~|sum_d;
            nf_q <= sum_d[WIDTH-1];
        end
    end
    assign zf = zf_q;
    assign nf = nf_q;
`endif

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign p         = wp_q;
    assign g         = wg_q;
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: directed vectors on 16- and 32-bit instances of cla_adder_pipe.
// Define CLA_ADDER_PIPE_FLAGS_EN to also check the zf/nf flags.
module tb_cla_adder_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, cin, sub;
    logic [15:0] a16, b16, sum16;
    logic [31:0] a32, b32, sum32;
    logic        rdy16, ov16, cout16, ovf16, p16, g16;
    logic        rdy32, ov32, cout32, ovf32, p32, g32;
`ifdef CLA_ADDER_PIPE_FLAGS_EN
    logic        zf16, nf16, zf32, nf32;
`endif
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic [15:0] a, b;
        logic        ci, sb;
        logic [15:0] s;
        logic        co, ov, pp, gg;
    } vec_t;
    vec_t v[$];

    always #5 clk = ~clk;

    cla_adder_pipe #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
        .a(a16), .b(b16), .cin(cin), .sub(sub),
        .out_valid(ov16), .out_ready(out_ready), .sum(sum16), .cout(cout16),
        .ovf(ovf16), .p(p16), .g(g16)
`ifdef CLA_ADDER_PIPE_FLAGS_EN
        , .zf(zf16), .nf(nf16)
`endif
    );

    cla_adder_pipe #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .a(a32), .b(b32), .cin(cin), .sub(sub),
        .out_valid(ov32), .out_ready(out_ready), .sum(sum32), .cout(cout32),
        .ovf(ovf32), .p(p32), .g(g32)
`ifdef CLA_ADDER_PIPE_FLAGS_EN
        , .zf(zf32), .nf(nf32)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Streams v[] back to back on the 16-bit instance; result k is visible two edges after its drive.
    task automatic run_vecs(input string name);
        for (int i = 0; i < v.size() + 2; i++) begin
            if (i < v.size()) begin
                in_valid = 1'b1;
                a16 = v[i].a;
                b16 = v[i].b;
                cin = v[i].ci;
                sub = v[i].sb;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i < v.size()) chk($sformatf("%s in_ready %0d", name, i), rdy16, 1);
            if (i >= 2) begin
                chk($sformatf("%s out_valid %0d", name, i - 2), ov16, 1);
                chk($sformatf("%s sum %0d", name, i - 2), sum16, v[i-2].s);
                chk($sformatf("%s cout %0d", name, i - 2), cout16, v[i-2].co);
                chk($sformatf("%s ovf %0d", name, i - 2), ovf16, v[i-2].ov);
                chk($sformatf("%s p %0d", name, i - 2), p16, v[i-2].pp);
                chk($sformatf("%s g %0d", name, i - 2), g16, v[i-2].gg);
`ifdef CLA_ADDER_PIPE_FLAGS_EN
                chk($sformatf("%s zf %0d", name, i - 2), zf16, v[i-2].s == 16'h0);
                chk($sformatf("%s nf %0d", name, i - 2), nf16, v[i-2].s[15]);
`endif
            end
            cyc();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cin = 1'b0;
        sub = 1'b0;
        a16 = '0; b16 = '0; a32 = '0; b32 = '0;
        repeat (2) cyc();
        chk("rst out_valid", ov16, 0);
        chk("rst sum", sum16, 0);
        chk("rst cout", cout16, 0);
        chk("rst ovf", ovf16, 0);
        chk("rst p", p16, 0);
        chk("rst g", g16, 0);
        chk("rst out_valid32", ov32, 0);
        rst_n = 1'b1;
        #1;
        chk("rst in_ready", rdy16, 1);

        // single add, exact 2-cycle latency
        cyc();
        out_ready = 1'b1;
        in_valid = 1'b1;
        a16 = 16'd65000;
        b16 = 16'd65340;
        #1;
        cyc();
        in_valid = 1'b0;
        #1;
        chk("t1 valid after 1", ov16, 0);
        cyc();
        chk("t1 valid after 2", ov16, 1);
        chk("t1 sum", sum16, 64804);
        chk("t1 cout", cout16, 1);
        chk("t1 ovf", ovf16, 0);
        chk("t1 p", p16, 0);
        chk("t1 g", g16, 1);

        v = {};
        v.push_back('{16'd58135, 16'd3592, 1'b0, 1'b0, 16'd61727, 1'b0, 1'b0, 1'b0, 1'b0});
        v.push_back('{16'd1005,  16'd69,   1'b1, 1'b0, 16'd1075,  1'b0, 1'b0, 1'b0, 1'b0});
        v.push_back('{16'd15124, 16'd5383, 1'b1, 1'b0, 16'd20508, 1'b0, 1'b0, 1'b0, 1'b0});
        run_vecs("b2b");

        v = {};
        v.push_back('{16'h00FF, 16'hFF00, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
        v.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1});
        v.push_back('{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0});
        run_vecs("edge");

        // 32-bit subtract, cin ignored
        a16 = '0; b16 = '0;
        sub = 1'b1;
        cin = 1'b1;
        in_valid = 1'b1;
        a32 = 32'd5;
        b32 = 32'd7;
        #1;
        chk("sub32 in_ready", rdy32, 1);
        cyc();
        a32 = 32'h8000_0000;
        b32 = 32'd1;
        #1;
        cyc();
        in_valid = 1'b0;
        sub = 1'b0;
        cin = 1'b0;
        #1;
        chk("sub32a valid", ov32, 1);
        chk("sub32a sum", sum32, 32'hFFFF_FFFE);
        chk("sub32a cout", cout32, 0);
        chk("sub32a ovf", ovf32, 0);
        chk("sub32a p", p32, 0);
        chk("sub32a g", g32, 0);
`ifdef CLA_ADDER_PIPE_FLAGS_EN
        chk("sub32a zf", zf32, 0);
        chk("sub32a nf", nf32, 1);
`endif
        cyc();
        chk("sub32b valid", ov32, 1);
        chk("sub32b sum", sum32, 32'h7FFF_FFFF);
        chk("sub32b cout", cout32, 1);
        chk("sub32b ovf", ovf32, 1);
        chk("sub32b g", g32, 1);
        cyc();
        chk("sub32 drained", ov32, 0);

        // backpressure: beats a=100+k, b=k
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int c = 0, nxt = 0; c < 4; c++) begin
            a16 = 16'(100 + nxt);
            b16 = 16'(nxt);
            #1;
            chk($sformatf("bp in_ready %0d", c), rdy16, c < 2);
            if (c >= 2) begin
                chk($sformatf("bp stall valid %0d", c), ov16, 1);
                chk($sformatf("bp stall sum %0d", c), sum16, 100);
            end
            if (c < 2) nxt++;
            cyc();
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("bp out0 valid", ov16, 1);
        chk("bp out0 sum", sum16, 100);
        cyc();
        chk("bp out1 valid", ov16, 1);
        chk("bp out1 sum", sum16, 102);
        cyc();
        chk("bp drained", ov16, 0);
        chk("bp hold sum", sum16, 102);

        // asynchronous reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1;
        a16 = 16'd1;
        b16 = 16'd1;
        #1;
        cyc();
        a16 = 16'd2;
        #1;
        cyc();
        chk("pre-rst valid", ov16, 1);
        chk("pre-rst sum", sum16, 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", ov16, 0);
        chk("async rst sum", sum16, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        #1;
        rst_n = 1'b1;
        #1;
        chk("post-rst in_ready", rdy16, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("post-rst no beat %0d", i), ov16, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
